// File: rtl/proc_pkg.sv
// proc_pkg: shared opcodes, instruction fields and FSM encoding for the 4-bit execute path
package proc_pkg;
  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_CLR0 = 4'b1100;
  localparam logic [3:0] OP_CLR1 = 4'b1110;
  localparam logic [3:0] OP_CLR2 = 4'b1111;
  localparam logic [3:0] SEL_IDLE = 4'b1111;
  localparam int OP_HI = 11;
  localparam int OP_LO = 8;
  localparam int RD_HI = 7;
  localparam int RD_LO = 6;
  localparam int RS_HI = 5;
  localparam int RS_LO = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  function automatic logic is_clr(input logic [3:0] op);
    return op inside {OP_CLR0, OP_CLR1, OP_CLR2};
  endfunction
  function automatic logic is_legal(input logic [3:0] op);
    return is_clr(op) || op inside {OP_LDI, OP_ADD, OP_SUB, OP_MUL, OP_NAND, OP_NOR, OP_XOR};
  endfunction
endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: instruction handshake plus ALU operand/result bus
interface exec_sequencer_if;
  logic [11:0] instr;
  logic instr_valid;
  logic instr_ready;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic [3:0] alu_f3;
  logic [3:0] alu_f4;
  logic alu_c;
  logic alu_v;
  modport slave(input instr, instr_valid, alu_f3, alu_f4, alu_c, alu_v, output instr_ready, alu_a, alu_b, alu_sel);
  modport master(output instr, instr_valid, alu_f3, alu_f4, alu_c, alu_v, input instr_ready, alu_a, alu_b, alu_sel);
endinterface

// File: rtl/reg_file_4x4.sv
// reg_file_4x4: 4x4-bit register file, two async read ports, debug read, two sync write ports
module reg_file_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ra_idx,
  input  logic [1:0] rb_idx,
  input  logic [1:0] dbg_idx,
  output logic [3:0] ra,
  output logic [3:0] rb,
  output logic [3:0] dbg,
  input  logic       we0,
  input  logic [1:0] wa0,
  input  logic [3:0] wd0,
  input  logic       we1,
  input  logic [1:0] wa1,
  input  logic [3:0] wd1
);
  logic [3:0] r [4];
  assign ra = r[ra_idx];
  assign rb = r[rb_idx];
  assign dbg = r[dbg_idx];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      if (we0) r[wa0] <= wd0;
      if (we1) r[wa1] <= wd1;
    end
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: IDLE/EXEC/WB controller driving the ALU and writing results back
module exec_sequencer
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  exec_sequencer_if.slave  bus,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             done,
  output logic             err,
  input  logic [1:0]       dbg_idx,
  output logic [3:0]       dbg_data
);
  state_t state;
  logic [3:0] op, imm, f3, f4, wd0;
  logic [1:0] rd, rs;
  logic c, v, legal, arith, we0, we1;
  assign legal = is_legal(op);
  assign arith = op == OP_ADD || op == OP_SUB;
  assign bus.instr_ready = state == IDLE;
  assign bus.alu_sel = (state == EXEC && legal && op != OP_LDI) ? op : SEL_IDLE;
  assign we0 = state == WB && legal;
  assign we1 = state == WB && op == OP_MUL;
  assign wd0 = is_clr(op) ? 4'd0 : op == OP_LDI ? imm : f3;
  reg_file_4x4 u_rf (
    .clk(clk), .rst(rst),
    .ra_idx(rd), .rb_idx(rs), .dbg_idx(dbg_idx),
    .ra(bus.alu_a), .rb(bus.alu_b), .dbg(dbg_data),
    .we0(we0), .wa0(rd), .wd0(wd0),
    .we1(we1), .wa1(rd + 2'd1), .wd1(f4)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {op, rd, rs, imm, f3, f4, c, v} <= '0;
      {flag_c, flag_v, flag_z} <= 3'b001;
      {done, err} <= 2'b00;
    end else begin
      done <= state == WB;
      err <= state == WB && !legal;
      if (state == IDLE && bus.instr_valid) begin
        op <= bus.instr[OP_HI:OP_LO];
        rd <= bus.instr[RD_HI:RD_LO];
        rs <= bus.instr[RS_HI:RS_LO];
        imm <= bus.instr[IMM_HI:IMM_LO];
        state <= EXEC;
      end else if (state == EXEC) begin
        {f4, f3, c, v} <= {bus.alu_f4, bus.alu_f3, bus.alu_c, bus.alu_v};
        state <= WB;
      end else if (state == WB) begin
        state <= IDLE;
        if (legal)
          flag_z <= op == OP_LDI ? imm == 4'd0 : is_clr(op) ? 1'b1 : op == OP_MUL ? {f4, f3} == 8'd0 : f3 == 4'd0;
        if (legal && op != OP_LDI) begin
          flag_c <= arith && c;
          flag_v <= arith && v;
        end
      end
    end
endmodule
